// File: rtl/result_uart_tx_if.sv
// Port bundle between the calculator (master) and the result UART transmitter (slave).
// start is a one-cycle request taken only when busy is low; busy stays high until the message ends.
interface result_uart_tx_if;
    logic        start;
    logic [31:0] result;
    logic        busy;
    logic        tx;
    logic        tx_done;
    logic [1:0]  state_dbg;

    modport master (
        output start,
        output result,
        input  busy,
        input  tx,
        input  tx_done,
        input  state_dbg
    );

    modport slave (
        input  start,
        input  result,
        output busy,
        output tx,
        output tx_done,
        output state_dbg
    );
endinterface

// File: rtl/result_uart_tx.sv
// Sends a 32-bit result as eight uppercase hex digits plus CR LF over an 8N1 UART line.
// Handshake: start is accepted only while busy is 0; result is latched in that same cycle.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    result_uart_tx_if.slave  bus
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      CHAR_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [3:0]      char_idx;
    logic [31:0]     result_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic [3:0]      nibble;
    logic [7:0]      cur_char;
    logic [2:0]      bit_next;
    logic            bit_end;

    // Character 0 is the most significant nibble; characters 8 and 9 are CR and LF.
    always_comb begin
        nibble = 4'h0;
        case (char_idx)
            4'd0:    nibble = result_q[31:28];
            4'd1:    nibble = result_q[27:24];
            4'd2:    nibble = result_q[23:20];
            4'd3:    nibble = result_q[19:16];
            4'd4:    nibble = result_q[15:12];
            4'd5:    nibble = result_q[11:8];
            4'd6:    nibble = result_q[7:4];
            4'd7:    nibble = result_q[3:0];
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        cur_char = 8'h0A;
        if (char_idx < 4'd8) begin
            if (nibble < 4'd10) begin
                cur_char = 8'h30 + {4'h0, nibble};
            end else begin
                cur_char = 8'h37 + {4'h0, nibble};
            end
        end else if (char_idx == 4'd8) begin
            cur_char = 8'h0D;
        end
    end

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign bit_next = bit_idx + 3'd1;

    // tx is registered and updated on the edge that ends each bit period, so the
    // line changes exactly on bit boundaries and the first start bit follows start by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            result_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    bit_cnt <= '0;
                    if (bus.start) begin
                        result_q <= bus.result;
                        char_idx <= 4'd0;
                        bit_idx  <= 3'd0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx_q    <= cur_char[0];
                        state   <= DATA_BITS;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                DATA_BITS: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_next;
                            tx_q    <= cur_char[bit_next];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                STOP_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (char_idx == CHAR_LAST) begin
                            char_idx <= 4'd0;
                            tx_q     <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            tx_q     <= 1'b0;
                            state    <= START_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.tx_done   = done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at four clocks per bit: table of messages plus
// hand-written sequences for ignored start, back-to-back start and mid-message reset.
module tb_result_uart_tx;

  localparam int CPB = 4;
  localparam int MSG_CYCLES = 401;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_uart_tx_if bus();

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] result;
    logic [79:0] msg;
  } vec_t;

  vec_t vecs[4];

  // Line receiver: detect start bit, re-check it one cycle later, then sample each bit one period apart.
  initial begin : uart_rx
    logic [7:0] b;
    b = '0;
    forever begin
      do @(negedge clk); while (bus.tx !== 1'b0);
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_msg(input logic [79:0] msg);
    for (int i = 0; i < 10; i++) exp_q.push_back(msg[79 - 8*i -: 8]);
  endtask

  task automatic pulse_start(input logic [31:0] r, input logic [31:0] r_after);
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.result = r;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.result = r_after;
    @(negedge clk);
    chk("latency_tx", 32'(bus.tx), 32'd0);
    chk("latency_busy", 32'(bus.busy), 32'd1);
    chk("latency_state", 32'(bus.state_dbg), 32'd1);
  endtask

  // Counts cycles from the first start bit (cycle 1) to tx_done; optional extra start at glitch_at.
  task automatic wait_done(input int glitch_at, output int cyc);
    cyc = 1;
    while (bus.tx_done !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == glitch_at);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_rx(input string name, input int base);
    int idx;
    logic [7:0] e;
    repeat (3) @(negedge clk);
    chk({name, "_nbytes"}, 32'(rx_q.size() - base), 32'(exp_q.size()));
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (idx < rx_q.size()) chk({name, "_byte"}, 32'(rx_q[idx]), 32'(e));
      else                   chk({name, "_byte_missing"}, 32'h100, 32'(e));
      idx++;
    end
  endtask

  task automatic run_msg(input string name, input logic [31:0] r, input logic [31:0] r_after,
                         input logic [79:0] msg, input int glitch_at);
    int base;
    int cyc;
    int d0;
    base = rx_q.size();
    d0   = done_cnt;
    expect_msg(msg);
    pulse_start(r, r_after);
    wait_done(glitch_at, cyc);
    chk({name, "_done_latency"}, 32'(cyc), 32'(MSG_CYCLES));
    chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({name, "_done_width"}, 32'(bus.tx_done), 32'd0);
    check_rx(name, base);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin : main
    int cyc;
    int base;
    int d0;
    int bad;

    bus.start  = 1'b0;
    bus.result = '0;
    rst = 1'b1;

    // Reset held for two edges, then ten idle cycles.
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b100);
    chk("reset_state", 32'(bus.state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b100);
    end

    vecs[0] = '{32'h0000_000A, 80'h3030_3030_3030_3041_0D0A};
    vecs[1] = '{32'h0123_ABCD, 80'h3031_3233_4142_4344_0D0A};
    vecs[2] = '{32'h9F8E_7D6C, 80'h3946_3845_3744_3643_0D0A};
    vecs[3] = '{32'h1000_0000, 80'h3130_3030_3030_3030_0D0A};

    for (int v = 0; v < 4; v++) begin
      run_msg($sformatf("table%0d", v), vecs[v].result, vecs[v].result, vecs[v].msg, 0);
    end

    // Input result changes right after acceptance; the latched value must be sent.
    run_msg("latch", 32'hDEAD_BEEF, 32'h1234_5678, 80'h4445_4144_4245_4546_0D0A, 0);

    // Second start while busy, carrying a different result, must be ignored.
    run_msg("ignored_start", 32'h5A5A_5A5A, 32'h3333_3333, 80'h3541_3541_3541_3541_0D0A, 50);

    // Start presented during the tx_done cycle begins the next message immediately.
    base = rx_q.size();
    expect_msg(80'h3030_3030_3030_3031_0D0A);
    expect_msg(80'h3030_3030_3030_3130_0D0A);
    pulse_start(32'h0000_0001, 32'h0000_0001);
    wait_done(0, cyc);
    chk("chain_first_latency", 32'(cyc), 32'(MSG_CYCLES));
    bus.start  = 1'b1;
    bus.result = 32'h0000_0010;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.result = 32'h0;
    @(negedge clk);
    chk("chain_restart", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b010);
    wait_done(0, cyc);
    chk("chain_second_latency", 32'(cyc), 32'(MSG_CYCLES));
    check_rx("chain", base);

    // Reset 150 cycles into a message aborts it without a done pulse.
    pulse_start(32'h1234_5678, 32'h1234_5678);
    for (int c = 2; c <= 150; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b100);
    chk("abort_state", 32'(bus.state_dbg), 32'd0);
    d0  = done_cnt;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_msg("after_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 80'h4646_4646_4646_4646_0D0A, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
